seg_tube_driver: RTL and testbench

- Memory-mapped responder for the 7-segment tube port on the CPU IO bus.
- Accepts the CPU's ioWrite/ioRead cycles at the tube addresses and latches a 32-bit display value plus a control word.
- Time-multiplexes the value as 8 hex digits onto the board's common anode/segment pins.
- Sits between the CPU IO decode and the physical tube pins.

---
 rtl/seg_tube_driver.sv | 100 ++++++++++
 tb/tb_seg_tube_driver.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seg_tube_driver.sv
// IO-mapped 7-segment tube driver: latches a 32-bit value and control word from
// the CPU IO bus and scans them out as 8 hex digits on one-hot anode lines.
module seg_tube_driver #(
  parameter logic [31:0] SEG_ADDR  = 32'hFFFF0014,
  parameter logic [31:0] CTRL_ADDR = 32'hFFFF0018,
  parameter int          SCAN_DIV  = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ioWrite,
  input  logic        ioRead,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [31:0]   value_q, value_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    seg_an_q, seg_an_d;
  logic [7:0]    seg_out_q, seg_out_d;

  logic [4:0]    shamt;
  logic [3:0]    nib;
  logic          blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    value_d    = value_q;
    ctrl_d     = ctrl_q;
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    seg_an_d   = 8'h00;
    seg_out_d  = 8'h00;

    if (ioWrite && addr == SEG_ADDR)  value_d = wdata;
    if (ioWrite && addr == CTRL_ADDR) ctrl_d  = wdata[1:0];

    if (scan_cnt_q == CNT_MAX) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 3'd1;
    end

    shamt = {idx_q, 2'b00};
    nib   = value_q[shamt +: 4];
    // digit 0 is never blanked so a zero value still shows "0"
    blank = ctrl_q[1] && (idx_q != 3'd0) && ((value_q >> shamt) == 32'd0);

    if (ctrl_q[0] && !blank) begin
      seg_an_d  = 8'b1 << idx_q;
      seg_out_d = {1'b0, hex7(nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      value_q    <= 32'h0;
      ctrl_q     <= 2'b01;
      scan_cnt_q <= '0;
      idx_q      <= 3'd0;
      seg_an_q   <= 8'h00;
      seg_out_q  <= 8'h00;
    end else begin
      value_q    <= value_d;
      ctrl_q     <= ctrl_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_an_q   <= seg_an_d;
      seg_out_q  <= seg_out_d;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (ioRead && addr == SEG_ADDR)       rdata = value_q;
    else if (ioRead && addr == CTRL_ADDR) rdata = {30'b0, ctrl_q};
  end

  assign seg_an  = seg_an_q;
  assign seg_out = seg_out_q;

endmodule

// File: tb/tb_seg_tube_driver.sv
// Randomized bench for seg_tube_driver against a cycle-count based display model.
module tb_seg_tube_driver;
  localparam int DIV = 4;
  localparam logic [31:0] SEG  = 32'hFFFF0014;
  localparam logic [31:0] CTRL = 32'hFFFF0018;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        io_write = 1'b0, io_read = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] rdata;
  logic [7:0]  seg_an, seg_out;

  int n_tests = 0, n_fail = 0;

  seg_tube_driver #(.SEG_ADDR(SEG), .CTRL_ADDR(CTRL), .SCAN_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .ioWrite(io_write), .ioRead(io_read),
    .addr(addr), .wdata(wdata), .rdata(rdata), .seg_an(seg_an), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  // reference model: digit position derived from edges counted since reset release
  logic [7:0]  hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  logic [31:0] m_value = 32'h0;
  logic [1:0]  m_ctrl  = 2'b01;
  int          m_n     = 0;
  logic [7:0]  e_an = 8'h00, e_out = 8'h00;

  function automatic int cur_idx();
    return (m_n / DIV) % 8;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_value = 32'h0; m_ctrl = 2'b01; m_n = 0; e_an = 8'h00; e_out = 8'h00;
    end else begin
      int i;
      logic [31:0] upper;
      i = cur_idx();
      upper = m_value / (32'd1 << (4 * i));
      if (!m_ctrl[0] || (m_ctrl[1] && i != 0 && upper == 32'd0)) begin
        e_an = 8'h00; e_out = 8'h00;
      end else begin
        e_an  = 8'h00; e_an[i] = 1'b1;
        e_out = hex_tab[upper % 16];
      end
      if (io_write && addr == SEG)  m_value = wdata;
      if (io_write && addr == CTRL) m_ctrl  = wdata[1:0];
      m_n = m_n + 1;
    end
  end

  function automatic logic [31:0] m_rdata(input logic r, input logic [31:0] a);
    if (r && a == SEG)  return m_value;
    if (r && a == CTRL) return {30'b0, m_ctrl};
    return 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // one bus cycle: check registered outputs, drive inputs, check readback
  task automatic cyc(input logic r_n, input logic w, input logic r,
                     input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    chk("seg_an", {24'h0, seg_an}, {24'h0, e_an});
    chk("seg_out", {24'h0, seg_out}, {24'h0, e_out});
    rst = r_n; io_write = w; io_read = r; addr = a; wdata = d;
    #1;
    chk("rdata", rdata, m_rdata(r, a));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  logic [31:0] rnd_addr;

  initial begin
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(2);
    chk("first_an", {24'h0, seg_an}, 32'h01);
    chk("first_out", {24'h0, seg_out}, 32'h3F);

    cyc(1'b1, 1'b1, 1'b0, SEG, 32'h1234ABCD);
    idle(8 * DIV + 3);
    cyc(1'b1, 1'b1, 1'b0, CTRL, 32'h3);
    cyc(1'b1, 1'b1, 1'b0, SEG, 32'h000000F0);
    idle(8 * DIV + 3);
    cyc(1'b1, 1'b0, 1'b1, SEG, 32'h0);
    cyc(1'b1, 1'b0, 1'b1, CTRL, 32'h0);
    cyc(1'b1, 1'b0, 1'b1, 32'hFFFF0010, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'hFFFF0000, 32'hDEADBEEF);
    cyc(1'b1, 1'b0, 1'b1, SEG, 32'h0);
    chk("ignored_wr", rdata, 32'h000000F0);
    cyc(1'b1, 1'b1, 1'b0, CTRL, 32'h0);
    idle(3 * DIV + 1);
    cyc(1'b1, 1'b1, 1'b0, CTRL, 32'h1);
    idle(2 * DIV);

    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 4))
        0: rnd_addr = SEG;
        1: rnd_addr = CTRL;
        2: rnd_addr = 32'hFFFF0010;
        3: rnd_addr = 32'hFFFF0000;
        default: rnd_addr = $urandom;
      endcase
      cyc(1'b1, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, rnd_addr,
          $urandom >> (4 * $urandom_range(0, 7)));
    end

    for (int k = 0; k < 64 && cur_idx() != 5; k++) idle(1);
    chk("reach_idx5", cur_idx(), 5);
    cyc(1'b0, 1'b1, 1'b0, SEG, 32'hCAFEF00D);
    cyc(1'b1, 1'b0, 1'b1, SEG, 32'h0);
    chk("rst_an", {24'h0, seg_an}, 32'h00);
    chk("rst_val", rdata, 32'h0);
    cyc(1'b1, 1'b0, 1'b1, CTRL, 32'h0);
    chk("rst_ctrl", rdata, 32'h1);
    chk("restart_an", {24'h0, seg_an}, 32'h01);
    idle(8 * DIV + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
